// File: rtl/aes_host_driver.sv
// rtl/aes_host_driver.sv - host-side dword sequencer for the aes core
module aes_host_driver #(
    parameter int unsigned DONE_TIMEOUT = 64,
    parameter int unsigned READ_LAT     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_plaintext,
    input  logic [127:0] req_key,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_ciphertext,
    output logic         rsp_timeout,
    output logic         busy,
    output logic         aes_start_n,
    output logic         aes_start_read_n,
    output logic [31:0]  aes_dword_in,
    input  logic [31:0]  aes_dword_out,
    input  logic         aes_done
);

    // One counter serves the load index, the done wait and the read phases.
    localparam int unsigned CW_RAW = $clog2(DONE_TIMEOUT + READ_LAT + 1);
    localparam int unsigned CW     = (CW_RAW > 4) ? CW_RAW : 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_DONE,
        S_RD_PULSE,
        S_RD_WAIT,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [127:0]    pt_q;
    logic [127:0]    key_q;
    logic [127:0]    ct_q;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic            rsp_timeout_q;
    logic            busy_q;
    logic            start_n_q;
    logic            start_read_n_q;
    logic [31:0]     dword_q;
    logic [31:0]     load_word_d;

    // Dword presented in load slot idx; slots 0 and 1 both carry the first plaintext word.
    function automatic logic [31:0] load_word(input logic [127:0] p, input logic [127:0] k,
                                              input logic [3:0] idx);
        logic [31:0] w;
        case (idx)
            4'd0, 4'd1: w = p[127:96];
            4'd2:       w = p[95:64];
            4'd3:       w = p[63:32];
            4'd4:       w = p[31:0];
            4'd5:       w = k[127:96];
            4'd6:       w = k[95:64];
            4'd7:       w = k[63:32];
            default:    w = k[31:0];
        endcase
        return w;
    endfunction

    // Next load dword: slot 0 comes straight from the request, later slots from the latched block.
    always_comb begin
        load_word_d = 32'd0;
        if (state_q == S_IDLE) begin
            load_word_d = load_word(req_plaintext, req_key, 4'd0);
        end else begin
            load_word_d = load_word(pt_q, key_q, 4'(cnt_q) + 4'd1);
        end
    end

    // Main sequencer: every output is a register updated here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            pt_q           <= '0;
            key_q          <= '0;
            ct_q           <= '0;
            req_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_timeout_q  <= 1'b0;
            busy_q         <= 1'b0;
            start_n_q      <= 1'b1;
            start_read_n_q <= 1'b1;
            dword_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!req_ready_q) begin
                        req_ready_q <= 1'b1;
                    end else if (req_valid) begin
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        pt_q        <= req_plaintext;
                        key_q       <= req_key;
                        start_n_q   <= 1'b0;
                        dword_q     <= load_word_d;
                        cnt_q       <= '0;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    start_n_q <= 1'b1;
                    if (cnt_q == CW'(8)) begin
                        dword_q <= '0;
                        cnt_q   <= '0;
                        state_q <= S_WAIT_DONE;
                    end else begin
                        dword_q <= load_word_d;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (aes_done) begin
                        start_read_n_q <= 1'b0;
                        state_q        <= S_RD_PULSE;
                    end else if (cnt_q == CW'(DONE_TIMEOUT - 1)) begin
                        ct_q          <= '0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RD_PULSE: begin
                    // cnt_q now counts edges since the core sampled start_read_n.
                    start_read_n_q <= 1'b1;
                    cnt_q          <= CW'(1);
                    state_q        <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (cnt_q == CW'(READ_LAT)) begin
                        ct_q    <= {ct_q[95:0], aes_dword_out};
                        cnt_q   <= CW'(1);
                        state_q <= S_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    // Shifting left leaves the first dword read in [127:96].
                    ct_q <= {ct_q[95:0], aes_dword_out};
                    if (cnt_q == CW'(3)) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q   <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        busy_q        <= 1'b0;
                        req_ready_q   <= 1'b1;
                        state_q       <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready        = req_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_ciphertext   = ct_q;
    assign rsp_timeout      = rsp_timeout_q;
    assign busy             = busy_q;
    assign aes_start_n      = start_n_q;
    assign aes_start_read_n = start_read_n_q;
    assign aes_dword_in     = dword_q;

endmodule
